spi_read: RTL and testbench



---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_in_sync.sv | 46 ++++
 rtl/spi_read.sv | 145 ++++++++++++++
 tb/tb_spi_read.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame definitions for the read responder and its input synchronizer.
`default_nettype none

package spi_pkg;

  localparam int HDR_BITS = 8;
  localparam int WR_BIT   = 7;

  typedef struct packed {
    logic       wr;
    logic [6:0] adr;
  } spi_hdr_t;

  typedef enum logic [2:0] {
    WAIT_CS = 3'd0,
    IDLE    = 3'd1,
    HDR     = 3'd2,
    SEND    = 3'd3,
    TAIL    = 3'd4,
    SKIP    = 3'd5
  } spi_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_in_sync.sv
// spi_in_sync: 2-FF synchronizer plus history FF for sclk/mosi/cs, with sclk rise/fall and cs rise pulses.
`default_nettype none

module spi_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic cs_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_rise_o,
  output logic mosi_o,
  output logic cs_o
);

  // Bit 0 = sclk, bit 1 = mosi, bit 2 = cs. Reset to 0 so a cs already low
  // at reset release never looks like a fresh frame start.
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      hist_q  <= 3'b000;
    end else begin
      sync1_q <= {cs_i, mosi_i, sclk_i};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign sclk_rise_o = sync2_q[0] & ~hist_q[0];
  assign sclk_fall_o = ~sync2_q[0] & hist_q[0];
  assign cs_rise_o   = sync2_q[2] & ~hist_q[2];
  assign mosi_o      = sync2_q[1];
  assign cs_o        = sync2_q[2];

  logic unused_hist;
  assign unused_hist = hist_q[1];

endmodule

`default_nettype wire

// File: rtl/spi_read.sv
// spi_read: SPI mode-0 slave read responder; shifts a din snapshot out on miso after a matching read header.
// Optional SPI_READ_CNT_EN appends an 8-bit completed-read counter after the data.
`default_nettype none

module spi_read
  import spi_pkg::*;
#(
  parameter int         Nbit      = 8,
  parameter logic [6:0] param_adr = 7'd1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sclk,
  input  logic            mosi,
  input  logic            cs,
  input  logic [Nbit-1:0] din,
  output logic            miso,
  output logic            miso_oe,
  output logic            rd_req,
  output logic            rd_done
);

`ifdef SPI_READ_CNT_EN
  localparam int TXW = Nbit + 8;
`else
  localparam int TXW = Nbit;
`endif
  localparam int              CW      = 6;
  localparam logic [CW-1:0]   HDR_END = CW'(HDR_BITS - 1);
  localparam logic [CW-1:0]   TX_END  = CW'(TXW - 1);

  logic sclk_rise, sclk_fall, cs_rise, mosi_s, cs_s;

  spi_in_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (sclk),
    .mosi_i      (mosi),
    .cs_i        (cs),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_rise_o   (cs_rise),
    .mosi_o      (mosi_s),
    .cs_o        (cs_s)
  );

  spi_rd_state_t         state_q;
  logic [CW-1:0]         cnt_q;
  logic [HDR_BITS-2:0]   hdr_q;
  logic [TXW-1:0]        tx_q;
  logic                  miso_q, miso_oe_q, rd_req_q, rd_done_q;

  spi_hdr_t              hdr_next;
  logic [TXW-1:0]        tx_load;
  logic [TXW-1:0]        tx_shift;

  assign hdr_next = spi_hdr_t'({hdr_q, mosi_s});
  assign tx_shift = tx_q << 1;

`ifdef SPI_READ_CNT_EN
  logic [7:0] rdcnt_q;
  assign tx_load = {din, rdcnt_q};
`else
  assign tx_load = din;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_CS;
      cnt_q     <= '0;
      hdr_q     <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_done_q <= 1'b0;
`ifdef SPI_READ_CNT_EN
      rdcnt_q   <= 8'h00;
`endif
    end else begin
      rd_req_q  <= 1'b0;
      rd_done_q <= 1'b0;
      // cs_rise has priority over any sclk edge seen in the same cycle.
      if (cs_rise && state_q != WAIT_CS) begin
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        state_q   <= IDLE;
        if (state_q == TAIL) begin
          rd_done_q <= 1'b1;
`ifdef SPI_READ_CNT_EN
          rdcnt_q   <= rdcnt_q + 8'd1;
`endif
        end
      end else begin
        case (state_q)
          WAIT_CS: if (cs_s) state_q <= IDLE;
          IDLE: if (!cs_s) begin
            state_q <= HDR;
            cnt_q   <= '0;
            hdr_q   <= '0;
          end
          HDR: if (sclk_rise) begin
            hdr_q <= hdr_next[HDR_BITS-2:0];
            if (cnt_q == HDR_END) begin
              cnt_q <= '0;
              if (!hdr_next.wr && hdr_next.adr == param_adr) begin
                tx_q      <= tx_load;
                miso_q    <= tx_load[TXW-1];
                miso_oe_q <= 1'b1;
                rd_req_q  <= 1'b1;
                state_q   <= SEND;
              end else begin
                state_q   <= SKIP;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          // cnt_q==0 marks the fall right after the header's last rise: no shift there.
          SEND: if (sclk_rise) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == TX_END) begin
              state_q <= TAIL;
              miso_q  <= 1'b0;
            end
          end else if (sclk_fall && cnt_q != '0) begin
            tx_q   <= tx_shift;
            miso_q <= tx_shift[TXW-1];
          end
          TAIL: miso_q <= 1'b0;
          SKIP: miso_oe_q <= 1'b0;
          default: state_q <= WAIT_CS;
        endcase
      end
    end
  end

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign rd_req  = rd_req_q;
  assign rd_done = rd_done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_read.sv
// tb_spi_read: directed MCU-side frames against a frame-level model of spi_read.
`default_nettype none

module tb_spi_read;

  localparam int NBIT = 8;
`ifdef SPI_READ_CNT_EN
  localparam int PAY = NBIT + 8;
`else
  localparam int PAY = NBIT;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sclk = 1'b0;
  logic            mosi = 1'b0;
  logic            cs = 1'b1;
  logic [NBIT-1:0] din = '0;
  logic            miso, miso_oe, rd_req, rd_done;

  spi_read #(.Nbit(NBIT), .param_adr(7'd1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs      (cs),
    .din     (din),
    .miso    (miso),
    .miso_oe (miso_oe),
    .rd_req  (rd_req),
    .rd_done (rd_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int unsigned cyc = 0;
  int          req_n = 0;
  int          done_n = 0;
  logic        oe_seen = 1'b0;
  int unsigned req_cyc = 0;
  logic [7:0]  cnt_m = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-cycle compare: pulse bookkeeping and "miso is 0 whenever not driven".
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_req) begin
        req_n++;
        req_cyc = cyc;
      end
      if (rd_done) done_n++;
      if (miso_oe) oe_seen = 1'b1;
      else check("miso_idle", miso, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_payload(input logic [7:0] hdr, input logic [NBIT-1:0] d,
                                                input logic [7:0] c);
    logic [63:0] p;
    p = 64'd0;
`ifdef SPI_READ_CNT_EN
    p = {40'd0, d, c};
`else
    p = {56'd0, d};
    if (c == 8'hFF) p = p;
`endif
    if (hdr[7] || hdr[6:0] != 7'd1) p = 64'd0;
    return p;
  endfunction

  // Runs one MCU frame: header, then ndata payload bits; optional reset pulse
  // before header bit rst_at; optional din change in the middle of the payload.
  task automatic frame(input logic [7:0] hdr, input int ndata, input int rst_at, input bit flip,
                       output logic [63:0] rx, output int unsigned rise8, output logic oe_d0);
    rx = 64'd0;
    rise8 = 0;
    oe_d0 = 1'b0;
    req_n = 0;
    done_n = 0;
    oe_seen = 1'b0;
    tick(1);
    cs = 1'b0;
    tick(5);
    for (int i = 0; i < 8 + ndata; i++) begin
      mosi = (i < 8) ? hdr[7-i] : 1'b0;
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      if (i == 9 && flip) din = ~din;
      tick(5);
      if (i >= 8) rx = {rx[62:0], miso};
      if (i == 8) oe_d0 = miso_oe;
      sclk = 1'b1;
      if (i == 7) rise8 = cyc;
      tick(5);
      sclk = 1'b0;
    end
    tick(5);
    cs = 1'b1;
    tick(10);
  endtask

  task automatic run(input string tag, input logic [7:0] hdr, input int ndata, input int rst_at,
                     input bit flip, output logic [63:0] rx);
    logic [63:0]     exp_pay;
    logic [NBIT-1:0] d0;
    int unsigned     rise8;
    logic            oe_d0;
    bit              resp;
    bit              full;
    d0 = din;
    if (rst_at >= 0) cnt_m = 8'h00;
    resp = (model_payload(hdr, d0, cnt_m) != 64'd0 || (!hdr[7] && hdr[6:0] == 7'd1)) && rst_at < 0;
    full = (ndata == PAY);
    exp_pay = resp ? (model_payload(hdr, d0, cnt_m) >> (PAY - ndata)) : 64'd0;
    frame(hdr, ndata, rst_at, flip, rx, rise8, oe_d0);
    din = d0;
    check({tag, "_data"}, rx, exp_pay);
    check({tag, "_rd_req"}, req_n, resp ? 1 : 0);
    check({tag, "_rd_done"}, done_n, (resp && full) ? 1 : 0);
    check({tag, "_oe_seen"}, oe_seen, resp);
    check({tag, "_oe_after"}, miso_oe, 0);
    if (resp) begin
      check({tag, "_oe_first"}, oe_d0, 1);
      check({tag, "_req_lat"}, req_cyc - rise8, 3);
    end
    if (resp && full) cnt_m = cnt_m + 8'd1;
  endtask

  logic [63:0] rx;

  initial begin
    tick(3);
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_req", rd_req, 0);
    check("rst_done", rd_done, 0);
    rst_n = 1'b1;
    tick(10);

    din = 8'hA5;
    run("rd_a5", 8'h01, PAY, -1, 1'b0, rx);
    check("lit_a5", rx[PAY-1 -: 8], 8'hA5);

    run("wr_adr1", 8'h81, PAY, -1, 1'b0, rx);
    run("rd_adr2", 8'h02, PAY, -1, 1'b0, rx);

    din = 8'h96;
    run("abort3", 8'h01, 3, -1, 1'b0, rx);
    check("lit_abort3", rx[2:0], 3'b100);
    din = 8'h5A;
    run("rd_5a_flip", 8'h01, PAY, -1, 1'b1, rx);
    check("lit_5a", rx[PAY-1 -: 8], 8'h5A);

    din = 8'hE7;
    run("rst_hdr", 8'h01, PAY, 4, 1'b0, rx);

`ifdef SPI_READ_CNT_EN
    din = 8'h3C;
    run("cnt0", 8'h01, PAY, -1, 1'b0, rx);
    check("lit_cnt0", rx[7:0], 8'h00);
    run("cnt1", 8'h01, PAY, -1, 1'b0, rx);
    check("lit_cnt1", rx[7:0], 8'h01);
    run("cnt2", 8'h01, PAY, -1, 1'b0, rx);
    check("lit_cnt2", rx[15:0], 16'h3C02);
    run("cnt_ab1", 8'h01, NBIT + 3, -1, 1'b0, rx);
    run("cnt_ab2", 8'h01, NBIT + 5, -1, 1'b0, rx);
    run("cnt3", 8'h01, PAY, -1, 1'b0, rx);
    check("lit_cnt3", rx[7:0], 8'h03);
`endif

    din = 8'hC3;
    run("rd_c3", 8'h01, PAY, -1, 1'b0, rx);
    check("lit_c3", rx[PAY-1 -: 8], 8'hC3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
